afifo_wr_arb: RTL and testbench
===============================

# afifo_wr_arb

Write-side arbiter sharing the single write port of the asynchronous FIFO between N_REQ producers in the write-clock domain. Grants are round-robin and held for a whole burst (up to MAX_BURST words or until the producer marks last), so words from one producer stay contiguous in the FIFO. The block gates every push with the FIFO full flag and never pushes into a full FIFO.

## Interface
- D_WIDTH, 8, data word width (from shared package)
- N_REQ, 4, number of producers (2..8)
- MAX_BURST, 4, max words per grant (1..F_DEPTH)
- wclk  in  1  write-domain clock; all logic on rising edge
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  producer i has a word on req_data[i]
- req_data  in  N_REQ x D_WIDTH  producer words
- req_last  in  N_REQ  word is last of producer's burst
- req_ready  out  N_REQ  word i accepted this cycle when req_valid[i] & req_ready[i]
- fifo_wfull  in  1  FIFO full flag (write domain)
- fifo_winc  out  1  push strobe to FIFO
- fifo_wdata  out  D_WIDTH  word pushed
- gnt_onehot  out  N_REQ  current grant, one-hot; 0 in IDLE
- busy  out  1  high in BURST

## Operation
- FSM states IDLE, BURST; registers state, gnt_idx, rr_ptr, burst_cnt.
- IDLE: if any req_valid, pick first i in order rr_ptr, rr_ptr+1, ... wrapping at N_REQ-1 -> 0; next state BURST, gnt_idx=i, burst_cnt=0. No transfer in IDLE; req_ready all 0.
- BURST: req_ready[gnt_idx] = ~fifo_wfull; other req_ready 0. fifo_winc = req_valid[gnt_idx] & ~fifo_wfull; fifo_wdata = req_data[gnt_idx] (combinational mux; don't-care when fifo_winc=0).
- On each transfer burst_cnt++. Burst ends on a transfer with req_last[gnt_idx]=1 or burst_cnt==MAX_BURST-1: next state IDLE, rr_ptr = gnt_idx+1 mod N_REQ.
- Granted producer dropping req_valid mid-burst: grant held, no timeout, no transfer until it reasserts.
- fifo_wfull high: stall, no transfer, grant and burst_cnt unchanged.
- Widths: gnt_idx, rr_ptr $clog2(N_REQ) bits with explicit wrap compare (N_REQ need not be power of 2); burst_cnt $clog2(MAX_BURST)+1 bits.

## Timing
- Reset (async assert, sync to wclk on release): state IDLE, gnt_idx 0, rr_ptr 0, burst_cnt 0; outputs req_ready 0, fifo_winc 0, fifo_wdata 0 (masked), gnt_onehot 0, busy 0.
- Reset mid-burst: outputs drop immediately on wrst_n low; partial burst abandoned; FIFO contents untouched.
- Arbitration latency: req_valid seen in IDLE at cycle n -> grant and first possible push at cycle n+1.
- Throughput: one word per cycle in BURST while valid and not full; one idle cycle between bursts.
- fifo_wfull combinational to req_ready and fifo_winc, same cycle.
- Single-word burst (MAX_BURST=1 or last on first word): BURST lasts one transfer cycle.

## Structure
- Shared package afifo_pkte: D_WIDTH, ADDRS, F_DEPTH, data_ty already present; add N_REQ default, MAX_BURST default, arb state enum typedef (IDLE, BURST) and req index typedef.
- Sub-module afifo_rr_pick: combinational round-robin picker (inputs req vector, rr_ptr; outputs found, index). Instantiated once.

## Test plan
- Single producer 1 sends 3 words A0,A1,A2 with last on A2, FIFO empty -> grant cycle then 3 consecutive fifo_winc with A0..A2; back to IDLE; rr_ptr=2.
- All 4 producers valid continuously, no last, MAX_BURST=4 -> bursts of exactly 4 words in order 0,1,2,3,0; one idle cycle between bursts.
- fifo_wfull high for 5 cycles mid-burst after 2 words -> fifo_winc and req_ready 0 for those 5 cycles; remaining 2 words follow; burst totals 4.
- Granted producer drops valid 3 cycles mid-burst while producer 2 valid -> no grant change, no pushes; burst resumes and completes before producer 2 granted.
- wrst_n low during BURST after 1 word -> all outputs 0 immediately; after release with only producer 3 valid -> producer 3 granted (rr_ptr 0 search).
- N_REQ=3, producer 2 finishes burst -> rr_ptr wraps to 0; producer 0 granted next.

Source files
------------

// File: rtl/afifo_pkte.sv
// Shared definitions for the asynchronous FIFO and its write-side arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package afifo_pkte;

    localparam int D_WIDTH = 8;
    localparam int ADDRS   = 4;
    localparam int F_DEPTH = 1 << ADDRS;

    typedef logic [D_WIDTH-1:0] data_ty;

    // Defaults for the write arbiter; instances may override them.
    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/afifo_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping at N_REQ-1.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is asserted.
// Ports: req (request vector), rr_ptr (search start), found, idx (winning index).
module afifo_rr_pick
    import afifo_pkte::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // Walk the offsets from the far end back to zero so that the smallest
    // offset (the highest-priority candidate) is the last one to win.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            // Explicit wrap: N_REQ need not be a power of two.
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter sharing the async FIFO write port among N_REQ producers.
// Latency: grant one cycle after req_valid seen in IDLE; then one word per cycle.
// Backpressure: fifo_wfull combinationally clears req_ready/fifo_winc; grant and count hold.
// Ports: wclk/wrst_n; req_valid/req_data/req_last/req_ready per producer;
//        fifo_wfull in, fifo_winc/fifo_wdata out; gnt_onehot and busy status.
module afifo_wr_arb
    import afifo_pkte::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][D_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]                req_last,
    output logic [N_REQ-1:0]                req_ready,
    input  logic                            fifo_wfull,
    output logic                            fifo_winc,
    output logic [D_WIDTH-1:0]              fifo_wdata,
    output logic [N_REQ-1:0]                gnt_onehot,
    output logic                            busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    arb_state_t     state;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  rr_ptr;
    logic [CW-1:0]  burst_cnt;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           xfer;
    logic           burst_done;
    logic [IW-1:0]  next_ptr;

    afifo_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // The full flag feeds ready and push directly so a word is never
    // offered to the FIFO in a cycle where it cannot land.
    always_comb begin
        req_ready  = '0;
        xfer       = 1'b0;
        if (state == BURST) begin
            req_ready[gnt_idx] = ~fifo_wfull;
            xfer               = req_valid[gnt_idx] & ~fifo_wfull;
        end
        fifo_winc  = xfer;
        // Masked to zero when idle so the bus is quiet out of reset.
        fifo_wdata = xfer ? req_data[gnt_idx] : '0;
        burst_done = xfer & (req_last[gnt_idx] | (burst_cnt == LAST_CNT));
        next_ptr   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            gnt_onehot <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= BURST;
                        gnt_idx    <= pick_idx;
                        burst_cnt  <= '0;
                        gnt_onehot <= N_REQ'(1) << pick_idx;
                        busy       <= 1'b1;
                    end
                end
                BURST: begin
                    // A stalled or silent producer keeps the grant indefinitely.
                    if (burst_done) begin
                        state      <= IDLE;
                        rr_ptr     <= next_ptr;
                        burst_cnt  <= '0;
                        gnt_onehot <= '0;
                        busy       <= 1'b0;
                    end else if (xfer) begin
                        burst_cnt  <= burst_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arb.sv
module tb_afifo_wr_arb;
    import afifo_pkte::*;

    logic wclk = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    // Four-producer instance
    logic [3:0]          req_valid;
    logic [3:0][7:0]     req_data;
    logic [3:0]          req_last;
    logic [3:0]          req_ready;
    logic                fifo_wfull;
    logic                fifo_winc;
    logic [7:0]          fifo_wdata;
    logic [3:0]          gnt_onehot;
    logic                busy;

    // Three-producer instance
    logic [2:0]          req_valid3;
    logic [2:0][7:0]     req_data3;
    logic [2:0]          req_last3;
    logic [2:0]          req_ready3;
    logic                fifo_winc3;
    logic [7:0]          fifo_wdata3;
    logic [2:0]          gnt_onehot3;
    logic                busy3;

    int vectors = 0;
    int errors  = 0;

    // Producer models: word = producer*16 + accepted-word count; last when count hits last_at.
    logic [7:0] wcnt [4];
    logic [7:0] last_at [4];
    logic [7:0] wcnt3 [3];
    logic [7:0] last3 [3];

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < 4; i++) wcnt[i] <= 8'd0;
            for (int i = 0; i < 3; i++) wcnt3[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (req_valid[i] & req_ready[i]) wcnt[i] <= wcnt[i] + 8'd1;
            for (int i = 0; i < 3; i++)
                if (req_valid3[i] & req_ready3[i]) wcnt3[i] <= wcnt3[i] + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 8'(i * 16) + wcnt[i];
            req_last[i] = (wcnt[i] == last_at[i]);
        end
        for (int i = 0; i < 3; i++) begin
            req_data3[i] = 8'(i * 16) + wcnt3[i];
            req_last3[i] = (wcnt3[i] == last3[i]);
        end
    end

    afifo_wr_arb #(.N_REQ(4), .MAX_BURST(4)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .gnt_onehot (gnt_onehot),
        .busy       (busy)
    );

    afifo_wr_arb #(.N_REQ(3), .MAX_BURST(4)) dut3 (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid3),
        .req_data   (req_data3),
        .req_last   (req_last3),
        .req_ready  (req_ready3),
        .fifo_wfull (1'b0),
        .fifo_winc  (fifo_winc3),
        .fifo_wdata (fifo_wdata3),
        .gnt_onehot (gnt_onehot3),
        .busy       (busy3)
    );

    // Expected-observation packing: {gnt, ready, busy, winc, wdata}
    function automatic logic [17:0] ev(logic [3:0] g, logic [3:0] r, logic b, logic w, logic [7:0] d);
        return {g, r, b, w, d};
    endfunction

    function automatic logic [13:0] ev3(logic [2:0] g, logic [2:0] r, logic b, logic w, logic [7:0] d);
        return {g, r, b, w, d};
    endfunction

    task automatic do_reset();
        @(posedge wclk); #1;
        wrst_n = 1'b0;
        req_valid = 4'b0; req_valid3 = 3'b0; fifo_wfull = 1'b0;
        @(posedge wclk); #1;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        logic [13:0] obs3;
        req_valid = 4'b0; req_valid3 = 3'b0; fifo_wfull = 1'b0;
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        for (int i = 0; i < 3; i++) last3[i] = 8'hFF;
        #12;
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs, 18'h0);
        end
        obs3 = {gnt_onehot3, req_ready3, busy3, fifo_winc3, fifo_wdata3};
        vectors++;
        if (obs3 !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs_n3: got %h want %h", obs3, 14'h0);
        end
        @(posedge wclk); #1;
        wrst_n = 1'b1;
    endtask

    // Producer 1 sends 3 words, then producers 0 and 2 contend with rr_ptr at 2.
    task automatic test_single();
        logic [17:0] obs, exp;
        last_at[1] = 8'd2; last_at[0] = 8'd0; last_at[2] = 8'd0;
        for (int c = 0; c < 8; c++) begin
            @(posedge wclk); #1;
            case (c)
                0: req_valid = 4'b0010;
                4: req_valid = 4'b0000;
                5: req_valid = 4'b0101;
                7: req_valid = 4'b0000;
                default: ;
            endcase
            case (c)
                1: exp = ev(4'b0010, 4'b0010, 1'b1, 1'b1, 8'h10);
                2: exp = ev(4'b0010, 4'b0010, 1'b1, 1'b1, 8'h11);
                3: exp = ev(4'b0010, 4'b0010, 1'b1, 1'b1, 8'h12);
                6: exp = ev(4'b0100, 4'b0100, 1'b1, 1'b1, 8'h20);
                default: exp = 18'h0;
            endcase
            @(negedge wclk);
            obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_burst c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    // All four producers stream continuously with no last: 4-word bursts 0,1,2,3,0.
    task automatic test_all4();
        logic [17:0] obs, exp;
        int ph, p, k;
        do_reset();
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        for (int c = 0; c < 26; c++) begin
            @(posedge wclk); #1;
            if (c == 0)  req_valid = 4'b1111;
            if (c == 25) req_valid = 4'b0000;
            ph = c % 5;
            if (ph == 0 || c == 25) begin
                exp = 18'h0;
            end else begin
                p = (c / 5) % 4;
                k = (c / 20) * 4 + ph - 1;
                exp = ev(4'(1 << p), 4'(1 << p), 1'b1, 1'b1, 8'(p * 16 + k));
            end
            @(negedge wclk);
            obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL all4_rr c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    // FIFO full for 5 cycles after two words of a burst.
    task automatic test_wfull();
        logic [17:0] obs, exp;
        do_reset();
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        for (int c = 0; c < 11; c++) begin
            @(posedge wclk); #1;
            case (c)
                0:  req_valid  = 4'b0001;
                3:  fifo_wfull = 1'b1;
                8:  fifo_wfull = 1'b0;
                10: req_valid  = 4'b0000;
                default: ;
            endcase
            case (c)
                1: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h00);
                2: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h01);
                3, 4, 5, 6, 7: exp = ev(4'b0001, 4'b0000, 1'b1, 1'b0, 8'h00);
                8: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h02);
                9: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h03);
                default: exp = 18'h0;
            endcase
            @(negedge wclk);
            obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wfull_stall c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    // Granted producer 0 goes quiet for 3 cycles while producer 2 waits.
    task automatic test_drop_valid();
        logic [17:0] obs, exp;
        do_reset();
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        last_at[2] = 8'd0;
        for (int c = 0; c < 11; c++) begin
            @(posedge wclk); #1;
            case (c)
                0:  req_valid = 4'b0101;
                2:  req_valid = 4'b0100;
                5:  req_valid = 4'b0101;
                10: req_valid = 4'b0000;
                default: ;
            endcase
            case (c)
                1: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h00);
                2, 3, 4: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b0, 8'h00);
                5: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h01);
                6: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h02);
                7: exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h03);
                9: exp = ev(4'b0100, 4'b0100, 1'b1, 1'b1, 8'h20);
                default: exp = 18'h0;
            endcase
            @(negedge wclk);
            obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL drop_valid c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    // Reset asserted mid-burst; afterwards only producer 3 requests.
    task automatic test_reset_mid();
        logic [17:0] obs, exp;
        do_reset();
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        last_at[3] = 8'd0;
        @(posedge wclk); #1;
        req_valid = 4'b0001;
        @(posedge wclk); #1;
        exp = ev(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h00);
        @(negedge wclk);
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rstmid_first_word: got %h want %h", obs, exp);
        end
        @(posedge wclk); #1;
        wrst_n = 1'b0;
        req_valid = 4'b1000;
        #2;
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_async_drop: got %h want %h", obs, 18'h0);
        end
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        @(negedge wclk);
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_idle_after_release: got %h want %h", obs, 18'h0);
        end
        @(posedge wclk); #1;
        exp = ev(4'b1000, 4'b1000, 1'b1, 1'b1, 8'h30);
        @(negedge wclk);
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rstmid_grant_p3: got %h want %h", obs, exp);
        end
        @(posedge wclk); #1;
        req_valid = 4'b0000;
        @(negedge wclk);
        obs = {gnt_onehot, req_ready, busy, fifo_winc, fifo_wdata};
        vectors++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_end_idle: got %h want %h", obs, 18'h0);
        end
    endtask

    // Three producers: grant 1, then 2 (rr_ptr wraps to 0), then 0.
    task automatic test_wrap3();
        logic [13:0] obs, exp;
        do_reset();
        for (int i = 0; i < 3; i++) last3[i] = 8'd0;
        for (int c = 0; c < 7; c++) begin
            @(posedge wclk); #1;
            case (c)
                0: req_valid3 = 3'b010;
                2: req_valid3 = 3'b111;
                6: req_valid3 = 3'b000;
                default: ;
            endcase
            case (c)
                1: exp = ev3(3'b010, 3'b010, 1'b1, 1'b1, 8'h10);
                3: exp = ev3(3'b100, 3'b100, 1'b1, 1'b1, 8'h20);
                5: exp = ev3(3'b001, 3'b001, 1'b1, 1'b1, 8'h00);
                default: exp = 14'h0;
            endcase
            @(negedge wclk);
            obs = {gnt_onehot3, req_ready3, busy3, fifo_winc3, fifo_wdata3};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n3_wrap c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_wfull();
        test_drop_valid();
        test_reset_mid();
        test_wrap3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
